dm_scan_ctrl: RTL and testbench

- Parametrised, byte-addressed little-endian data memory with a debug front end. It is the next-generation DM block behind the board switch panel.
- Adds signed and unsigned sub-word loads, misalignment detection, and edge-triggered single-shot writes, so a held switch does not rewrite every cycle.
- Adds an auto-scan engine that walks memory one word per dwell tick and presents the result on a display word for the seg7x16 driver.

---
 rtl/dm_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dm_scan_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_scan_ctrl.sv
// Byte-addressed little-endian data memory with a switch-driven write port,
// sign/zero-extending sub-word reads and an auto-scan display engine.
module dm_scan_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DIV_W  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              wr_lock,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  input  logic [2:0]        dm_type,
  input  logic              en_scan,
  input  logic              slow,
  output logic [31:0]       dout,
  output logic [31:0]       disp_data,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              misalign,
  output logic              wr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DIV_W-1:0] TERM_SLOW = '1;
  localparam logic [DIV_W-1:0] TERM_FAST = DIV_W'((1 << (DIV_W - 2)) - 1);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;

  logic [7:0]        mem_q [DEPTH];
  logic              sync1_q, sync2_q, edge_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic [31:0]       dout_q, dout_d;
  logic [31:0]       disp_q, disp_d;
  logic              misalign_q, misalign_d;
  logic              wr_done_q;

  logic              is_half, is_byte, is_word, sext, mis;
  logic              strobe, commit, tick;
  logic [1:0]        addr_lo;
  logic [ADDR_W-1:0] a1, a2, a3, s1, s2, s3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       scan_word;

  always_comb begin
    is_half = (dm_type == 3'b001) || (dm_type == 3'b010);
    is_byte = (dm_type == 3'b011) || (dm_type == 3'b100);
    is_word = !is_half && !is_byte;
    sext    = (dm_type == 3'b001) || (dm_type == 3'b011);
    addr_lo = 2'(addr);
    mis     = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));

    a1 = addr + ADDR_W'(1);
    a2 = addr + ADDR_W'(2);
    a3 = addr + ADDR_W'(3);
    s1 = scan_addr_q + ADDR_W'(1);
    s2 = scan_addr_q + ADDR_W'(2);
    s3 = scan_addr_q + ADDR_W'(3);
    b0 = mem_q[addr];
    b1 = mem_q[a1];
    b2 = mem_q[a2];
    b3 = mem_q[a3];
    scan_word = {mem_q[s3], mem_q[s2], mem_q[s1], mem_q[scan_addr_q]};

    dout_d = '0;
    if (mis)
      dout_d = '0;
    else if (is_byte)
      dout_d = sext ? {{24{b0[7]}}, b0} : {24'h0, b0};
    else if (is_half)
      dout_d = sext ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
    else
      dout_d = {b3, b2, b1, b0};

    // Rising edge of the synchronised request; a held switch yields one strobe.
    strobe = sync2_q && !edge_q;
    commit = strobe && !wr_lock && !mis;
    // A blocked write leaves the flag alone; otherwise the read/write alignment rules agree.
    misalign_d = (strobe && wr_lock) ? misalign_q : mis;
  end

  always_comb begin
    tick  = en_scan && (cnt_q == (slow ? TERM_SLOW : TERM_FAST));
    cnt_d = cnt_q + DIV_W'(1);
    if (!en_scan || tick)
      cnt_d = '0;
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    disp_d      = disp_q;
    case (state_q)
      IDLE: begin
        disp_d      = dout_q;
        scan_addr_d = '0;
        if (en_scan)
          state_d = READ;
      end
      READ: begin
        disp_d  = scan_word;
        state_d = HOLD;
      end
      HOLD: begin
        if (tick) begin
          scan_addr_d = scan_addr_q + ADDR_W'(4);
          state_d     = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en_scan) begin
      state_d     = IDLE;
      scan_addr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      edge_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      scan_addr_q <= '0;
      dout_q      <= '0;
      disp_q      <= '0;
      misalign_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      sync1_q     <= wr_req;
      sync2_q     <= sync1_q;
      edge_q      <= sync2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      dout_q      <= dout_d;
      disp_q      <= disp_d;
      misalign_q  <= misalign_d;
      wr_done_q   <= commit;
      if (commit) begin
        mem_q[addr] <= din[7:0];
        if (!is_byte)
          mem_q[a1] <= din[15:8];
        if (is_word) begin
          mem_q[a2] <= din[23:16];
          mem_q[a3] <= din[31:24];
        end
      end
    end
  end

  assign dout      = dout_q;
  assign disp_data = disp_q;
  assign scan_addr = scan_addr_q;
  assign misalign  = misalign_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_dm_scan_ctrl.sv
// Self-checking bench for dm_scan_ctrl: manual reads/writes, scan walk, async reset abort.
module tb_dm_scan_ctrl;

  localparam int AW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst, wr_req, wr_lock, en_scan, slow;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic [2:0]    dm_type;
  logic [31:0]   dout, disp_data;
  logic [AW-1:0] scan_addr;
  logic          misalign, wr_done;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mm [16];
  logic [32:0] sb_q [$];
  logic [3:0]  scan_q [$];

  always #5 clk = ~clk;

  dm_scan_ctrl #(.ADDR_W(AW), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_lock(wr_lock), .addr(addr),
    .din(din), .dm_type(dm_type), .en_scan(en_scan), .slow(slow),
    .dout(dout), .disp_data(disp_data), .scan_addr(scan_addr),
    .misalign(misalign), .wr_done(wr_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [3:0] a);
    logic [3:0] a1, a2, a3;
    a1 = a + 4'd1;
    a2 = a + 4'd2;
    a3 = a + 4'd3;
    return {mm[a3], mm[a2], mm[a1], mm[a]};
  endfunction

  // {misalign, dout} expected for a manual read of the model memory
  function automatic logic [32:0] exp_rd(input logic [3:0] a, input logic [2:0] t);
    logic [3:0]  a1;
    logic [7:0]  b0;
    logic [15:0] h;
    a1 = a + 4'd1;
    b0 = mm[a];
    h  = {mm[a1], b0};
    case (t)
      3'b001:  return a[0] ? {1'b1, 32'h0} : {1'b0, {16{h[15]}}, h};
      3'b010:  return a[0] ? {1'b1, 32'h0} : {1'b0, 16'h0, h};
      3'b011:  return {1'b0, {24{b0[7]}}, b0};
      3'b100:  return {1'b0, 24'h0, b0};
      default: return (a[1:0] != 2'b00) ? {1'b1, 32'h0} : {1'b0, mword(a)};
    endcase
  endfunction

  task automatic rd(input string tag, input logic [3:0] a, input logic [2:0] t, input logic [32:0] exp);
    logic [32:0] e;
    sb_q.push_back(exp);
    addr    = a;
    dm_type = t;
    @(posedge clk); #1;
    e = sb_q.pop_front();
    $display("rd  %s a=%0d t=%b dout=%h mis=%b", tag, a, t, dout, misalign);
    check_val({tag, "_dout"}, dout, e[31:0]);
    check_val({tag, "_mis"}, 32'(misalign), 32'(e[32]));
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic [2:0] t,
                          input logic [31:0] d, input logic lock, input int hold,
                          input logic exp_commit, input logic exp_mis);
    int          pulses;
    logic [32:0] old;
    logic [3:0]  ax;
    pulses  = 0;
    addr    = a;
    dm_type = t;
    din     = d;
    wr_lock = lock;
    old     = exp_rd(a, t);
    wr_req  = 1'b1;
    for (int i = 0; i < hold + 6; i++) begin
      if (i == hold) wr_req = 1'b0;
      @(posedge clk); #1;
      if (wr_done) begin
        pulses++;
        check_val({tag, "_rbw"}, dout, old[31:0]);
      end
    end
    $display("wr  %s a=%0d t=%b d=%h lock=%b pulses=%0d mis=%b", tag, a, t, d, lock, pulses, misalign);
    check_val({tag, "_pulses"}, 32'(pulses), exp_commit ? 32'd1 : 32'd0);
    check_val({tag, "_mis"}, 32'(misalign), 32'(exp_mis));
    if (exp_commit) begin
      mm[a] = d[7:0];
      if (t == 3'b001 || t == 3'b010 || t == 3'b000) begin
        ax = a + 4'd1; mm[ax] = d[15:8];
      end
      if (t == 3'b000) begin
        ax = a + 4'd2; mm[ax] = d[23:16];
        ax = a + 4'd3; mm[ax] = d[31:24];
      end
    end
    wr_lock = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int          c, last, pulses;
    logic        first;
    logic [3:0]  prev, e;

    rst = 1'b1; wr_req = 1'b0; wr_lock = 1'b0; en_scan = 1'b0; slow = 1'b1;
    addr = '0; din = '0; dm_type = 3'b000;
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_dout", dout, 32'h0);
    check_val("rst_disp", disp_data, 32'h0);
    check_val("rst_scan", 32'(scan_addr), 32'h0);
    check_val("rst_mis", 32'(misalign), 32'h0);
    check_val("rst_wrdone", 32'(wr_done), 32'h0);
    rd("rst_w0", 4'd0, 3'b000, {1'b0, 32'h0});

    do_write("wb1", 4'd1, 3'b011, 32'h000000A5, 1'b0, 8, 1'b1, 1'b0);
    rd("h0s", 4'd0, 3'b001, {1'b0, 32'hFFFFA500});
    rd("h0u", 4'd0, 3'b010, {1'b0, 32'h0000A500});
    rd("b1u", 4'd1, 3'b100, {1'b0, 32'h000000A5});
    rd("b1s", 4'd1, 3'b011, {1'b0, 32'hFFFFFFA5});

    do_write("w4", 4'd4, 3'b000, 32'h12345678, 1'b0, 50, 1'b1, 1'b0);
    rd("w4", 4'd4, 3'b000, {1'b0, 32'h12345678});
    rd("h6u", 4'd6, 3'b010, {1'b0, 32'h00001234});
    rd("h5mis", 4'd5, 3'b010, {1'b1, 32'h0});
    rd("b7s", 4'd7, 3'b011, {1'b0, 32'h00000012});
    rd("t7word", 4'd4, 3'b111, {1'b0, 32'h12345678});

    do_write("wmis", 4'd2, 3'b000, 32'hDEADBEEF, 1'b0, 10, 1'b0, 1'b1);
    rd("wmis_w0", 4'd0, 3'b000, {1'b0, 32'h0000A500});
    rd("wmis_w4", 4'd4, 3'b000, {1'b0, 32'h12345678});
    do_write("hmis", 4'd3, 3'b001, 32'h0000BEEF, 1'b0, 10, 1'b0, 1'b1);
    do_write("wlock", 4'd4, 3'b000, 32'hDEADBEEF, 1'b1, 10, 1'b0, 1'b0);
    rd("wlock_w4", 4'd4, 3'b000, {1'b0, 32'h12345678});
    do_write("hw10", 4'd10, 3'b010, 32'hFFFF8001, 1'b0, 6, 1'b1, 1'b0);

    for (int a = 0; a < 12; a++)
      for (int t = 0; t < 5; t++)
        rd($sformatf("sweep_a%0d_t%0d", a, t), 4'(a), 3'(t), exp_rd(4'(a), 3'(t)));

    // Scan walk with slow dwell = 16 cycles
    do_write("pre0", 4'd0, 3'b000, 32'h0BADF00D, 1'b0, 6, 1'b1, 1'b0);
    do_write("pre8", 4'd8, 3'b000, 32'hCAFEBABE, 1'b0, 6, 1'b1, 1'b0);
    do_write("pre12", 4'd12, 3'b000, 32'h76543210, 1'b0, 6, 1'b1, 1'b0);
    scan_q.push_back(4'd4);
    scan_q.push_back(4'd8);
    scan_q.push_back(4'd12);
    scan_q.push_back(4'd0);
    scan_q.push_back(4'd4);
    addr = 4'd0; dm_type = 3'b000; slow = 1'b1;
    en_scan = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("scan_addr0", 32'(scan_addr), 32'h0);
    check_val("scan_disp0", disp_data, mword(4'd0));
    prev = scan_addr; c = 1; last = 0; first = 1'b1;
    while (scan_q.size() != 0 && c < 200) begin
      @(posedge clk); #1; c++;
      if (scan_addr !== prev) begin
        e = scan_q.pop_front();
        $display("scan cycle=%0d scan_addr=%0d", c, scan_addr);
        check_val("scan_addr", 32'(scan_addr), 32'(e));
        if (!first) check_val("scan_period", 32'(c - last), 32'd16);
        first = 1'b0; last = c; prev = scan_addr;
        @(posedge clk); #1; c++;
        check_val("scan_disp", disp_data, mword(e));
      end
    end
    if (scan_q.size() != 0) check_val("scan_timeout", 32'(scan_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    en_scan = 1'b0; addr = 4'd8; dm_type = 3'b000;
    @(posedge clk); #1;
    check_val("drop_scan_addr", 32'(scan_addr), 32'h0);
    @(posedge clk); #1;
    check_val("idle_disp", disp_data, mword(4'd8));
    repeat (20) @(posedge clk);
    #1;
    check_val("idle_stay", 32'(scan_addr), 32'h0);

    // Reset between request edge and strobe must abort the write
    addr = 4'd8; dm_type = 3'b000; din = 32'hFFFFFFFF; wr_lock = 1'b0;
    wr_req = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_val("arst_dout", dout, 32'h0);
    check_val("arst_disp", disp_data, 32'h0);
    check_val("arst_misc", {29'h0, wr_done, misalign, |scan_addr}, 32'h0);
    wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wr_done) pulses++;
    end
    check_val("arst_nowrite", 32'(pulses), 32'h0);
    for (int a = 0; a < 16; a += 4)
      rd($sformatf("arst_w%0d", a), 4'(a), 3'b000, {1'b0, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
